// File: rtl/alu_uart_ctrl_if.sv
// Signal bundle between the byte-stream ALU front end, the UART RX/TX pair and the ALU.
// master: the controller; slave: the UART/ALU side it talks to.
interface alu_uart_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 6
);
  logic [7:0]        rx_data;
  logic              rx_done;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic              tx_done;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_rdo;
  logic              alu_carry;
  logic              alu_zero;
  logic              busy;
  logic              rx_overrun;

  modport master (
    input  rx_data, rx_done, tx_busy, tx_done, alu_rdo, alu_carry, alu_zero,
    output tx_data, tx_start, alu_a, alu_b, alu_op, busy, rx_overrun
  );

  modport slave (
    output rx_data, rx_done, tx_busy, tx_done, alu_rdo, alu_carry, alu_zero,
    input  tx_data, tx_start, alu_a, alu_b, alu_op, busy, rx_overrun
  );
endinterface

// File: rtl/alu_uart_ctrl.sv
// Byte-stream front end for the 8-bit ALU: receives A, B and opcode bytes,
// holds them on the ALU inputs, then returns a result byte and a flags byte.
// Flags byte layout: {illegal, 5'b0, carry, zero}; illegal opcodes force res/carry/zero to 0.
module alu_uart_ctrl #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_uart_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    GET_A, GET_B, GET_OP, CALC, SEND_RES, WAIT_RES, SEND_FLG, WAIT_FLG
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] res;
  logic [7:0]        flg;
  logic              illegal;

  // Opcode byte is legal only with the two top bits clear and a supported function code.
  function automatic logic op_legal(input logic [7:0] op_byte);
    logic known;
    case (op_byte[5:0])
      6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h03, 6'h02, 6'h27: known = 1'b1;
      default:                                                 known = 1'b0;
    endcase
    return (op_byte[7:6] == 2'b00) && known;
  endfunction

  // Frame sequencer: all outputs are registered here; busy mirrors "not in a GET_* state".
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= GET_A;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.alu_op     <= '0;
      bus.tx_data    <= '0;
      bus.tx_start   <= 1'b0;
      bus.busy       <= 1'b0;
      bus.rx_overrun <= 1'b0;
      res            <= '0;
      flg            <= '0;
      illegal        <= 1'b0;
    end else begin
      bus.tx_start <= 1'b0;
      // Any byte arriving while a frame is being processed or answered is lost.
      if (bus.rx_done && bus.busy) begin
        bus.rx_overrun <= 1'b1;
      end
      case (state)
        GET_A: begin
          if (bus.rx_done) begin
            bus.alu_a <= bus.rx_data[DATA_W-1:0];
            state     <= GET_B;
          end
        end
        GET_B: begin
          if (bus.rx_done) begin
            bus.alu_b <= bus.rx_data[DATA_W-1:0];
            state     <= GET_OP;
          end
        end
        GET_OP: begin
          if (bus.rx_done) begin
            bus.alu_op <= bus.rx_data[OP_W-1:0];
            illegal    <= !op_legal(bus.rx_data);
            bus.busy   <= 1'b1;
            state      <= CALC;
          end
        end
        CALC: begin
          // ALU inputs have been stable for a full cycle; sample its outputs once.
          res   <= illegal ? '0 : bus.alu_rdo;
          flg   <= {illegal, 5'b00000, !illegal && bus.alu_carry, !illegal && bus.alu_zero};
          state <= SEND_RES;
        end
        SEND_RES: begin
          if (!bus.tx_busy) begin
            bus.tx_start <= 1'b1;
            bus.tx_data  <= res;
            state        <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          if (bus.tx_done) begin
            state <= SEND_FLG;
          end
        end
        SEND_FLG: begin
          if (!bus.tx_busy) begin
            bus.tx_start <= 1'b1;
            bus.tx_data  <= flg;
            state        <= WAIT_FLG;
          end
        end
        WAIT_FLG: begin
          if (bus.tx_done) begin
            illegal  <= 1'b0;
            bus.busy <= 1'b0;
            state    <= GET_A;
          end
        end
        default: state <= GET_A;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Scoreboard bench for alu_uart_ctrl: a stub ALU and a UART TX model surround the DUT,
// expected response bytes are queued at stimulus time and popped by a tx_start monitor.
module tb_alu_uart_ctrl;
  localparam int DATA_W = 8;
  localparam int OP_W   = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_uart_ctrl_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus ();
  alu_uart_ctrl #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic uart_busy = 1'b0;
  logic force_busy = 1'b0;
  logic busy_at_edge = 1'b0;
  int uart_delay = 4;
  int rst_count = 0;
  logic ovr_exp = 1'b0;
  logic [7:0] legal_ops [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h03, 8'h02, 8'h27};

  assign bus.tx_busy = uart_busy | force_busy;

  // Behavioural ALU: 9-bit result, bit 8 is carry/borrow. Unknown ops give deliberate garbage.
  function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
    logic signed [7:0] sa;
    sa = a;
    case (op)
      6'h20:   return {1'b0, a} + {1'b0, b};
      6'h22:   return {1'b0, a} - {1'b0, b};
      6'h24:   return {1'b0, a & b};
      6'h25:   return {1'b0, a | b};
      6'h26:   return {1'b0, a ^ b};
      6'h27:   return {1'b0, ~(a | b)};
      6'h03:   return {1'b0, 8'(sa >>> b[2:0])};
      6'h02:   return {1'b0, a >> b[2:0]};
      default: return {1'b1, a ^ b ^ 8'h5A};
    endcase
  endfunction

  logic [8:0] alu_full;
  assign alu_full      = alu_model(bus.alu_a, bus.alu_b, bus.alu_op);
  assign bus.alu_rdo   = alu_full[7:0];
  assign bus.alu_carry = alu_full[8];
  assign bus.alu_zero  = (alu_full[7:0] == 8'h00);

  // Expected {result byte, flags byte} for one frame.
  function automatic logic [15:0] expect_frame(input logic [7:0] a, input logic [7:0] b,
                                               input logic [7:0] op);
    logic [8:0] r;
    if (!(op inside {8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h03, 8'h02, 8'h27}))
      return {8'h00, 8'h80};
    r = alu_model(a, b, op[5:0]);
    return {r[7:0], 6'b000000, r[8], r[7:0] == 8'h00};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur within its cycle budget", name);
  endtask

  always @(posedge clk) begin
    busy_at_edge <= bus.tx_busy;
    if (!rst_n) rst_count <= rst_count + 1;
  end

  // Monitor: every tx_start pops one expected byte and checks pulse shape.
  initial begin
    logic prev_start;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_start === 1'b1) begin
        check("tx_start_width", prev_start, 0);
        check("tx_start_vs_busy", busy_at_edge, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got byte 0x%0h, required no transmission", bus.tx_data);
        end else begin
          check("tx_byte", bus.tx_data, exp_q.pop_front());
        end
      end
      prev_start = bus.tx_start;
    end
  end

  // UART transmitter model: busy for uart_delay cycles, then a one-cycle tx_done.
  initial begin
    logic [7:0] b;
    int rc;
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_start === 1'b1) begin
        b = bus.tx_data;
        rc = rst_count;
        uart_busy = 1'b1;
        repeat (uart_delay) @(negedge clk);
        if (rc == rst_count) begin
          check("tx_data_stable", bus.tx_data, b);
          bus.tx_done = 1'b1;
        end
        uart_busy = 1'b0;
        @(negedge clk);
        bus.tx_done = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] v);
    @(negedge clk);
    bus.rx_data = v;
    bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
  endtask

  task automatic wait_tx_start(input string name);
    int n = 0;
    @(negedge clk);
    while (bus.tx_start !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.tx_start !== 1'b1) fail_now(name);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    ovr_exp = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_alu_a"}, bus.alu_a, 0);
    check({tag, "_alu_b"}, bus.alu_b, 0);
    check({tag, "_alu_op"}, bus.alu_op, 0);
    check({tag, "_tx_data"}, bus.tx_data, 0);
    check({tag, "_tx_start"}, bus.tx_start, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_rx_overrun"}, bus.rx_overrun, 0);
  endtask

  // mode 0: plain frame; 1: extra rx byte during WAIT_RES; 2: tx_busy held 20 cycles in SEND_FLG
  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input int mode);
    logic [15:0] e;
    int n;
    e = expect_frame(a, b, op);
    exp_q.push_back(e[15:8]);
    exp_q.push_back(e[7:0]);
    send_byte(a);
    send_byte(b);
    send_byte(op);
    check("busy_after_op", bus.busy, 1);
    if (mode == 1) begin
      wait_tx_start("overrun_wait_start");
      @(negedge clk);
      bus.rx_data = 8'hEE;
      bus.rx_done = 1'b1;
      @(negedge clk);
      bus.rx_done = 1'b0;
      ovr_exp = 1'b1;
    end else if (mode == 2) begin
      wait_tx_start("hold_wait_start");
      force_busy = 1'b1;
      repeat (uart_delay + 4) @(negedge clk);
      n = 0;
      repeat (20) begin
        @(negedge clk);
        if (bus.tx_start !== 1'b0) n++;
      end
      check("hold_no_start", n, 0);
      force_busy = 1'b0;
    end
    n = 0;
    while (bus.busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy !== 1'b0) begin
      fail_now("frame_timeout");
      exp_q.delete();
      force_busy = 1'b0;
    end
    check("frame_bytes_sent", exp_q.size(), 0);
    check("alu_a_held", bus.alu_a, a);
    check("alu_b_held", bus.alu_b, b);
    check("alu_op_held", bus.alu_op, op[5:0]);
    check("rx_overrun", bus.rx_overrun, ovr_exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb, rop;
    bus.rx_data = 8'h00;
    bus.rx_done = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_state("por");

    uart_delay = 4;
    run_frame(8'h0F, 8'h01, 8'h20, 0);
    run_frame(8'hFF, 8'h01, 8'h20, 0);
    run_frame(8'h01, 8'h02, 8'h22, 0);
    run_frame(8'hF0, 8'h0F, 8'h24, 0);
    run_frame(8'h12, 8'h34, 8'h3F, 0);
    run_frame(8'h0F, 8'h01, 8'hA0, 0);
    run_frame(8'h5A, 8'h0F, 8'h26, 0);
    run_frame(8'h81, 8'h02, 8'h03, 1);
    uart_delay = 6;
    run_frame(8'h81, 8'h03, 8'h02, 2);

    // Reset right after the A byte discards the partial frame.
    uart_delay = 4;
    send_byte(8'h55);
    do_reset();
    check_reset_state("rst_after_a");
    run_frame(8'h03, 8'h05, 8'h25, 0);

    // Reset while waiting for the result byte to finish; also clears the sticky overrun.
    run_frame(8'h10, 8'h01, 8'h27, 1);
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h00);
    send_byte(8'h0F);
    send_byte(8'h01);
    send_byte(8'h20);
    wait_tx_start("rst_wait_res_start");
    do_reset();
    check_reset_state("rst_wait_res");
    repeat (uart_delay + 3) @(negedge clk);
    run_frame(8'h03, 8'h05, 8'h25, 0);

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rop = ($urandom_range(0, 3) == 0) ? 8'($urandom) : legal_ops[$urandom_range(0, 7)];
      uart_delay = $urandom_range(1, 6);
      run_frame(ra, rb, rop, 0);
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
